uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Parametrised, oversampling successor to the basic UART receiver: recovers asynchronous serial frames with a configurable number of data bits, optional parity and 1 or 2 stop bits. Each bit is sampled with a 3-sample majority vote. Received words are delivered over a valid/ready handshake with framing, parity and overrun status. It sits between the line input pin and the host-side consumer, fed by the shared baud generator running at baud × OVERSAMPLE.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5–9.
- PARITY, PAR_NONE: uart_pkg::parity_t; PAR_NONE, PAR_ODD or PAR_EVEN.
- STOP_BITS, 1: legal 1 or 2.
- OVERSAMPLE, 16: baud_tick pulses per bit period; even, ≥ 8.
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- baud_tick  in  1  one-clk strobe at baud × OVERSAMPLE, from the baud generator.
- rx_in  in  1  asynchronous serial line, idle high.
- rx_data  out  DATA_BITS  received word, LSB is the first bit on the wire.
- rx_valid  out  1  rx_data and status flags valid.
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready.
- frame_err  out  1  qualified by rx_valid; a stop bit sampled low.
- parity_err  out  1  qualified by rx_valid; parity mismatch, always 0 when PAR_NONE.
- overrun_err  out  1  one-clk pulse when a frame is dropped.

## Operation
- Synchronizer: 2 flops on rx_in, both reset to 1. All decisions use the synchronized line rx_s.
- State enum rx_state_t: IDLE, START, DATA, PARITY, STOP.
- Tick counter os_cnt, width $clog2(OVERSAMPLE). It advances only on baud_tick and wraps at OVERSAMPLE-1; that wrap is the bit boundary.
- IDLE: on baud_tick with rx_s = 0 and the previous ticked sample = 1, clear os_cnt and go to START.
- Majority vote: samples taken at os_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority, resolved on the tick at OVERSAMPLE/2+1.
- START: a resolved 1 is a false start; return to IDLE with no output. A resolved 0 moves to DATA at the bit boundary with bit_cnt = 0.
- DATA: shift the resolved bit into the MSB of shift_reg (LSB first on the wire). Move to PARITY, or to STOP when PARITY = PAR_NONE, at the boundary after bit DATA_BITS-1.
- PARITY: compare the resolved bit with the XOR of the data bits.
  - PAR_EVEN expects that XOR.
  - PAR_ODD expects its inverse.
  - A mismatch latches the internal parity flag.
- STOP: each stop bit is voted; any 0 latches the internal frame flag. At the resolution tick of the last stop bit, attempt delivery and go straight to IDLE without waiting for the bit boundary, so a back-to-back start edge is caught.
- Delivery:
  - If rx_valid = 0, or rx_ready = 1 in the same cycle, load rx_data, frame_err and parity_err, and set rx_valid.
  - Otherwise drop the new frame, keep the old word and flags, and pulse overrun_err.
- rx_valid clears on a handshake with no simultaneous load. rx_data and the flags are stable while rx_valid = 1.
- A frame with errors is still delivered, with its flags set.
- A break (line held low) yields one frame with data 0 and frame_err = 1. No further frame follows until rx_s returns high, because IDLE is edge-qualified.

## Timing
- Reset values:
  - rx_data = 0; rx_valid, frame_err, parity_err, overrun_err = 0.
  - State IDLE; os_cnt and bit_cnt = 0.
  - Synchronizer flops = 1.
- rx_in to rx_s latency: 2 clk.
- Start detection resolution: 1 baud_tick.
- rx_valid rises 1 clk after the resolution tick of the last stop bit.
- Handshake and load in the same cycle: old word consumed, new word loaded, rx_valid stays 1, no overrun.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded. After release, IDLE needs a fresh 1→0 edge.
- Cycles with baud_tick = 0 change only the synchronizer and the handshake logic.

## Structure
- Package uart_pkg: parity_t, rx_state_t, and a function parity_of(data) that returns the XOR reduction.
- Sub-module uart_sync: the 2-flop synchronizer, with a reset value parameter of 1. It is reusable by the TX loopback bench.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5 with rx_ready=1 -> rx_data=0xA5, rx_valid for 1 clk, all flags 0.
- 7E2, send 0x41 with the correct parity bit, then 0x41 with the parity bit flipped -> second word has parity_err=1, frame_err=0.
- 8N1, stop bit driven low, then line high -> rx_data delivered, frame_err=1. Next frame 0x3C is received cleanly.
- 3-clk low glitch on an idle line, and a 1-tick glitch inside a data bit -> no start for the first, and the vote restores the correct bit for the second.
- rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun_err pulses once. Raising rx_ready in the same cycle the second word would load instead yields 0x22 and no overrun.
- Assert rst_n low mid-DATA, release, send 0x5A -> all outputs 0 during reset, then 0x5A received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver and its companions.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= RESET_VAL;
      q       <= RESET_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-voted bits, optional parity, 1/2 stop bits,
// valid/ready delivery with framing, parity and overrun status.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int            CW    = $clog2(OVERSAMPLE);
  localparam int            BCW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0] SMP_A = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SMP_B = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] SMP_C = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] WRAP  = CW'(OVERSAMPLE - 1);

  logic rx_s;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_in),
    .q    (rx_s)
  );

  rx_state_t                state;
  logic [CW-1:0]            os_cnt;
  logic [BCW-1:0]           bit_cnt;
  logic                     prev_s;
  logic                     par_flag;
  logic                     frm_flag;
  logic                     vote_a;
  logic                     vote_b;
  logic [DATA_BITS-1:0]     shift_reg;
  logic                     at_res;
  logic                     at_wrap;
  logic                     maj;
  logic                     exp_par;
  logic                     last_stop;
  logic [MAX_DATA_BITS-1:0] data_ext;

  always_comb begin
    at_res    = baud_tick && (os_cnt == SMP_C);
    at_wrap   = baud_tick && (os_cnt == WRAP);
    maj       = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
    data_ext  = '0;
    data_ext[DATA_BITS-1:0] = shift_reg;
    exp_par   = (PARITY == PAR_ODD) ? ~parity_of(data_ext) : parity_of(data_ext);
    last_stop = (bit_cnt == BCW'(STOP_BITS - 1));
  end

  // The first two votes are held; the third is the live sample at SMP_C.
  always_ff @(posedge clk) begin
    if (baud_tick && (os_cnt == SMP_A)) vote_a <= rx_s;
    if (baud_tick && (os_cnt == SMP_B)) vote_b <= rx_s;
    if (at_res && (state == DATA)) shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      prev_s      <= 1'b1;
      par_flag    <= 1'b0;
      frm_flag    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (baud_tick) begin
        prev_s <= rx_s;
        if (state != IDLE) os_cnt <= (os_cnt == WRAP) ? '0 : os_cnt + CW'(1);
        case (state)
          IDLE: begin
            if (!rx_s && prev_s) begin
              os_cnt   <= '0;
              par_flag <= 1'b0;
              frm_flag <= 1'b0;
              state    <= START;
            end
          end
          START: begin
            if (at_res && maj) begin
              state <= IDLE;
            end else if (at_wrap) begin
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
          DATA: begin
            if (at_wrap) begin
              if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
              end else begin
                bit_cnt <= bit_cnt + BCW'(1);
              end
            end
          end
          uart_pkg::PARITY: begin
            if (at_res && (maj != exp_par)) par_flag <= 1'b1;
            if (at_wrap) begin
              bit_cnt <= '0;
              state   <= STOP;
            end
          end
          STOP: begin
            // Leave at the last stop bit's vote so a back-to-back start edge is not missed.
            if (at_res) begin
              if (!maj) frm_flag <= 1'b1;
              if (last_stop) begin
                state <= IDLE;
                if (!rx_valid || rx_ready) begin
                  rx_data    <= shift_reg;
                  frame_err  <= frm_flag | ~maj;
                  parity_err <= par_flag;
                  rx_valid   <= 1'b1;
                end else begin
                  overrun_err <= 1'b1;
                end
              end
            end
            if (at_wrap) bit_cnt <= bit_cnt + BCW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8N1 and a 7E2 receiver driven with
// directed and random frames, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int OS   = 16;
  localparam int TDIV = 8;

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       baud_tick = 1'b0;
  logic [1:0] rx_line;
  logic [1:0] rx_ready;
  logic [7:0] d8;
  logic       v8, fe8, pe8, ov8;
  logic [6:0] d7;
  logic       v7, fe7, pe7, ov7;

  int   checks = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   ovr_cnt[2];
  int   vcyc[2];
  int   words[2];
  bit   prev_stall[2];
  logic [10:0] prev_word[2];

  uart_rx_os #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .OVERSAMPLE(OS)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_in(rx_line[0]),
    .rx_data(d8), .rx_valid(v8), .rx_ready(rx_ready[0]),
    .frame_err(fe8), .parity_err(pe8), .overrun_err(ov8));

  uart_rx_os #(.DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2), .OVERSAMPLE(OS)) u_7e2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_in(rx_line[1]),
    .rx_data(d7), .rx_valid(v7), .rx_ready(rx_ready[1]),
    .frame_err(fe7), .parity_err(pe7), .overrun_err(ov7));

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      baud_tick = (c == TDIV - 1);
      c = (c + 1) % TDIV;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int idx);
    return (idx == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int idx);
    if (idx == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic qpush(input int idx, input exp_t e);
    if (idx == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic monitor(input int idx, input logic v, input logic rdy, input logic [8:0] data,
                         input logic fe, input logic pe, input logic ov);
    exp_t e;
    logic [10:0] w;
    w = {fe, pe, data};
    if (ov) ovr_cnt[idx]++;
    if (v) vcyc[idx]++;
    if (prev_stall[idx] && v) check($sformatf("stable_word%0d", idx), 32'(w), 32'(prev_word[idx]));
    if (v && rdy) begin
      words[idx]++;
      if (qsize(idx) == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_word%0d actual=%0h required=none", idx, data);
      end else begin
        e = qpop(idx);
        check($sformatf("data%0d", idx), 32'(data), 32'(e.data));
        check($sformatf("frame_err%0d", idx), 32'(fe), 32'(e.fe));
        check($sformatf("parity_err%0d", idx), 32'(pe), 32'(e.pe));
      end
    end
    prev_stall[idx] = v && !rdy;
    prev_word[idx]  = w;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      monitor(0, v8, rx_ready[0], {1'b0, d8}, fe8, pe8, ov8);
      monitor(1, v7, rx_ready[1], {2'b00, d7}, fe7, pe7, ov7);
    end else begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end
  end

  // Drive line idx to v for n baud ticks; returns just after the n-th tick edge.
  task automatic hold(input int idx, input logic v, input int n);
    rx_line[idx] = v;
    repeat (n) begin
      do @(posedge clk); while (baud_tick !== 1'b1);
    end
    #1;
  endtask

  // Frame-level model: expected word is the masked data, parity error when the
  // data plus sent parity bit carry an odd number of ones, frame error on any low stop.
  task automatic send_frame(input int idx, input logic [8:0] data, input bit flip,
                            input bit [1:0] stop_lvl, input int glitch_bit,
                            input bit push, input bit race);
    int         nb;
    int         ns;
    bit         pen;
    logic [8:0] d;
    logic       par_bit;
    bit         bits[$];
    exp_t       e;
    nb  = (idx == 0) ? 8 : 7;
    ns  = (idx == 0) ? 1 : 2;
    pen = (idx == 1);
    d   = data & ((9'd1 << nb) - 9'd1);
    par_bit = ($countones(d) % 2 == 1) ^ flip;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(par_bit);
    for (int s = 0; s < ns; s++) bits.push_back(stop_lvl[s]);
    e.data = d;
    e.pe   = pen && ((($countones(d) + int'(par_bit)) % 2) != 0);
    e.fe   = (stop_lvl[0] == 1'b0) || (ns == 2 && stop_lvl[1] == 1'b0);
    if (push) qpush(idx, e);
    foreach (bits[j]) begin
      if (j == glitch_bit) begin
        hold(idx, bits[j], 9);
        hold(idx, !bits[j], 1);
        hold(idx, bits[j], 6);
      end else if (race && j == bits.size() - 1) begin
        hold(idx, bits[j], 10);
        repeat (7) @(posedge clk);
        #1 rx_ready[idx] = 1'b1;
        @(posedge clk);
        #1 rx_ready[idx] = 1'b0;
        hold(idx, bits[j], 5);
      end else begin
        hold(idx, bits[j], 16);
      end
    end
  endtask

  task automatic drain(input int idx);
    int n;
    n = 0;
    while (qsize(idx) != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check($sformatf("drain%0d", idx), 32'(qsize(idx)), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   ob;
    exp_t brk;
    rx_line  = 2'b11;
    rx_ready = 2'b11;
    #2 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_valid", 32'(v8), 32'd0);
    check("rst_data", 32'(d8), 32'd0);
    check("rst_flags", 32'({fe8, pe8, ov8, fe7, pe7, ov7, v7}), 32'd0);
    rst_n = 1'b1;
    hold(0, 1'b1, 4);

    // 8N1 basic word with immediate acceptance
    base = vcyc[0];
    send_frame(0, 9'h0A5, 1'b0, 2'b11, -1, 1'b1, 1'b0);
    hold(0, 1'b1, 4);
    drain(0);
    check("a5_valid_cycles", 32'(vcyc[0] - base), 32'd1);

    // 7E2: correct parity, then flipped parity
    send_frame(1, 9'h041, 1'b0, 2'b11, -1, 1'b1, 1'b0);
    hold(1, 1'b1, 3);
    send_frame(1, 9'h041, 1'b1, 2'b11, -1, 1'b1, 1'b0);
    hold(1, 1'b1, 3);
    drain(1);

    // Stop bit low, then a clean word
    send_frame(0, 9'h096, 1'b0, 2'b10, -1, 1'b1, 1'b0);
    hold(0, 1'b1, 6);
    send_frame(0, 9'h03C, 1'b0, 2'b11, -1, 1'b1, 1'b0);
    hold(0, 1'b1, 4);
    drain(0);

    // Break: one zero word with frame error, nothing more while low
    base = words[0];
    brk.data = 9'h000;
    brk.fe   = 1'b1;
    brk.pe   = 1'b0;
    q0.push_back(brk);
    hold(0, 1'b0, 16 * 14);
    hold(0, 1'b1, 8);
    drain(0);
    check("break_words", 32'(words[0] - base), 32'd1);

    // Short low glitch on an idle line
    base = words[0];
    rx_line[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_line[0] = 1'b1;
    hold(0, 1'b1, 40);
    check("idle_glitch_words", 32'(words[0] - base), 32'd0);

    // One-tick glitch inside data bits
    send_frame(0, 9'h05B, 1'b0, 2'b11, 3, 1'b1, 1'b0);
    hold(0, 1'b1, 3);
    send_frame(1, 9'h02D, 1'b0, 2'b11, 5, 1'b1, 1'b0);
    hold(1, 1'b1, 3);
    drain(0);
    drain(1);

    // Overrun: consumer stalled across two back-to-back frames
    ob = ovr_cnt[0];
    rx_ready[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11, -1, 1'b1, 1'b0);
    send_frame(0, 9'h022, 1'b0, 2'b11, -1, 1'b0, 1'b0);
    hold(0, 1'b1, 4);
    check("overrun_pulses", 32'(ovr_cnt[0] - ob), 32'd1);
    check("overrun_kept_data", 32'(d8), 32'h11);
    check("overrun_kept_valid", 32'(v8), 32'd1);
    rx_ready[0] = 1'b1;
    drain(0);
    hold(0, 1'b1, 2);

    // Handshake in the same cycle as the next load
    rx_ready[0] = 1'b0;
    send_frame(0, 9'h033, 1'b0, 2'b11, -1, 1'b1, 1'b0);
    send_frame(0, 9'h044, 1'b0, 2'b11, -1, 1'b1, 1'b1);
    hold(0, 1'b1, 4);
    check("race_no_overrun", 32'(ovr_cnt[0] - ob), 32'd1);
    check("race_new_data", 32'(d8), 32'h44);
    rx_ready[0] = 1'b1;
    drain(0);

    // Reset in the middle of a data bit
    hold(0, 1'b0, 16);
    hold(0, 1'b1, 16);
    hold(0, 1'b0, 8);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(v8), 32'd0);
    check("midrst_data", 32'(d8), 32'd0);
    check("midrst_flags", 32'({fe8, pe8, ov8}), 32'd0);
    rx_line[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_hold_data", 32'(d8), 32'd0);
    rst_n = 1'b1;
    hold(0, 1'b1, 4);
    send_frame(0, 9'h05A, 1'b0, 2'b11, -1, 1'b1, 1'b0);
    hold(0, 1'b1, 4);
    drain(0);

    // Random frames on both receivers
    for (int i = 0; i < 16; i++) begin
      int         idx;
      logic [8:0] rd;
      bit         rflip;
      bit [1:0]   rstop;
      int         gb;
      idx   = i % 2;
      rd    = 9'($urandom_range(0, 255));
      rflip = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      gb    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : -1;
      send_frame(idx, rd, rflip, rstop, gb, 1'b1, 1'b0);
      hold(idx, 1'b1, $urandom_range(1, 5));
      drain(idx);
    end

    hold(0, 1'b1, 8);
    check("final_overruns0", 32'(ovr_cnt[0]), 32'd1);
    check("final_overruns1", 32'(ovr_cnt[1]), 32'd0);
    check("final_q0", 32'(q0.size()), 32'd0);
    check("final_q1", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
